// File: rtl/alu_station_pkg.sv
// Shared definitions for the ALU reservation station: word/tag types, unit tags,
// write-back port to tag mapping, and the operand wakeup helper.
`ifndef ALU_STATION_DEFS
`define ALU_STATION_DEFS
`define WORD_T     logic [31:0]
`define REGTAG_T   logic [2:0]
`define UNLOCKED   3'd0
`define ALU_MASTER 3'd1
`define ALU_SALVER 3'd2
`define LOAD_STORE 3'd3
`define ZERO       32'd0
`endif

package alu_station_pkg;

   localparam int WORD_W = 32;
   localparam int TAG_W  = 3;
   localparam int NUM_WB = 3;

   typedef struct packed {
      `WORD_T   data;
      `REGTAG_T tag;
   } opnd_t;

   // Write-back port N carries results of this unit; must match the register status file.
   function automatic `REGTAG_T wb_tag(input int port);
      case (port)
         0:       return `ALU_MASTER;
         1:       return `ALU_SALVER;
         default: return `LOAD_STORE;
      endcase
   endfunction

   // Capture a broadcast into a locked operand; port 0 wins if several match.
   function automatic opnd_t snoop(input opnd_t o, input logic [NUM_WB-1:0] en,
                                   input `WORD_T d0, input `WORD_T d1, input `WORD_T d2);
      opnd_t r;
      r = o;
      if (o.tag != `UNLOCKED) begin
         if (en[0] && o.tag == wb_tag(0))      r = {d0, `UNLOCKED};
         else if (en[1] && o.tag == wb_tag(1)) r = {d1, `UNLOCKED};
         else if (en[2] && o.tag == wb_tag(2)) r = {d2, `UNLOCKED};
      end
      return r;
   endfunction

endpackage

// File: rtl/alu_station_rs_pick.sv
// Lowest-index priority encoder: one-hot grant plus the binary index of the grant.
module rs_pick #(
   parameter int DEPTH = 4,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0] req,
   output logic [DEPTH-1:0] grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = |req;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (req[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            idx      = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/alu_station.sv
// Compacting reservation station feeding the ALU; index 0 is the oldest entry.
// Optional flush input enabled by defining ALU_STATION_FLUSH_EN.
module alu_station
   import alu_station_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int OP_W  = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rdy,
`ifdef ALU_STATION_FLUSH_EN
   input  logic            flush,
`endif
   input  logic            disp_valid,
   input  logic [OP_W-1:0] disp_op,
   input  `WORD_T          disp_imm,
   input  `WORD_T          disp_datax,
   input  `REGTAG_T        disp_tagx,
   input  `WORD_T          disp_datay,
   input  `REGTAG_T        disp_tagy,
   output logic            full,
   input  logic            en_w0,
   input  `WORD_T          write_data0,
   input  logic            en_w1,
   input  `WORD_T          write_data1,
   input  logic            en_w2,
   input  `WORD_T          write_data2,
   output logic            iss_valid,
   input  logic            iss_ready,
   output logic [OP_W-1:0] iss_op,
   output `WORD_T          iss_x,
   output `WORD_T          iss_y,
   output `WORD_T          iss_imm
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] valid_q, valid_n;
   logic [OP_W-1:0]  op_q  [DEPTH];
   logic [OP_W-1:0]  op_n  [DEPTH];
   `WORD_T           imm_q [DEPTH];
   `WORD_T           imm_n [DEPTH];
   opnd_t            x_q   [DEPTH];
   opnd_t            x_n   [DEPTH];
   opnd_t            y_q   [DEPTH];
   opnd_t            y_n   [DEPTH];

   // Copies with one empty slot on top so the shift-down never reads out of range.
   logic             valid_e [DEPTH+1];
   logic [OP_W-1:0]  op_e    [DEPTH+1];
   `WORD_T           imm_e   [DEPTH+1];
   opnd_t            x_e     [DEPTH+1];
   opnd_t            y_e     [DEPTH+1];

   logic [CNT_W-1:0]  count, wr_idx;
   logic [DEPTH-1:0]  ready_vec, grant;
   logic [IDX_W-1:0]  sel_idx;
   logic              sel_any, fire, accept, do_flush;
   logic [NUM_WB-1:0] wb_en;

`ifdef ALU_STATION_FLUSH_EN
   assign do_flush = flush;
`else
   assign do_flush = 1'b0;
`endif

   assign wb_en = {en_w2, en_w1, en_w0};

   always_comb begin
      count = '0;
      for (int i = 0; i < DEPTH; i++) begin
         count = count + CNT_W'(valid_q[i]);
         ready_vec[i] = valid_q[i] && (x_q[i].tag == `UNLOCKED) && (y_q[i].tag == `UNLOCKED);
      end
   end

   assign full = (count == CNT_W'(DEPTH));

   rs_pick #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_pick (
      .req   (ready_vec),
      .grant (grant),
      .idx   (sel_idx),
      .any   (sel_any)
   );

   always_comb begin
      iss_valid = sel_any;
      iss_op    = '0;
      iss_x     = `ZERO;
      iss_y     = `ZERO;
      iss_imm   = `ZERO;
      for (int i = 0; i < DEPTH; i++) begin
         if (grant[i]) begin
            iss_op  = op_q[i];
            iss_x   = x_q[i].data;
            iss_y   = y_q[i].data;
            iss_imm = imm_q[i];
         end
      end
   end

   assign fire   = rdy && sel_any && iss_ready;
   assign accept = rdy && disp_valid && !full && !do_flush;
   assign wr_idx = fire ? count - CNT_W'(1) : count;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         valid_e[i] = valid_q[i];
         op_e[i]    = op_q[i];
         imm_e[i]   = imm_q[i];
         x_e[i]     = x_q[i];
         y_e[i]     = y_q[i];
      end
      valid_e[DEPTH] = 1'b0;
      op_e[DEPTH]    = '0;
      imm_e[DEPTH]   = `ZERO;
      x_e[DEPTH]     = {`ZERO, `UNLOCKED};
      y_e[DEPTH]     = {`ZERO, `UNLOCKED};
   end

   // Shift above the issued slot, snoop the (possibly shifted) copy, then place the dispatch.
   always_comb begin
      valid_n = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (fire && (i >= int'(sel_idx))) begin
            valid_n[i] = valid_e[i+1];
            op_n[i]    = op_e[i+1];
            imm_n[i]   = imm_e[i+1];
            x_n[i]     = x_e[i+1];
            y_n[i]     = y_e[i+1];
         end else begin
            valid_n[i] = valid_e[i];
            op_n[i]    = op_e[i];
            imm_n[i]   = imm_e[i];
            x_n[i]     = x_e[i];
            y_n[i]     = y_e[i];
         end
         x_n[i] = snoop(x_n[i], wb_en, write_data0, write_data1, write_data2);
         y_n[i] = snoop(y_n[i], wb_en, write_data0, write_data1, write_data2);
         if (accept && (i == int'(wr_idx))) begin
            valid_n[i] = 1'b1;
            op_n[i]    = disp_op;
            imm_n[i]   = disp_imm;
            x_n[i]     = snoop({disp_datax, disp_tagx}, wb_en, write_data0, write_data1, write_data2);
            y_n[i]     = snoop({disp_datay, disp_tagy}, wb_en, write_data0, write_data1, write_data2);
         end
         if (do_flush) valid_n[i] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            op_q[i]  <= '0;
            imm_q[i] <= `ZERO;
            x_q[i]   <= {`ZERO, `UNLOCKED};
            y_q[i]   <= {`ZERO, `UNLOCKED};
         end
      end else if (rdy) begin
         valid_q <= valid_n;
         for (int i = 0; i < DEPTH; i++) begin
            op_q[i]  <= op_n[i];
            imm_q[i] <= imm_n[i];
            x_q[i]   <= x_n[i];
            y_q[i]   <= y_n[i];
         end
      end
   end

endmodule

// File: tb/tb_alu_station.sv
// Directed bench for alu_station: dispatch, wakeup, forwarding, compaction,
// full-drop, rdy freeze and reset scrub, each checked against hand-computed values.
module tb_alu_station;

   localparam logic [2:0] T_U = 3'd0;
   localparam logic [2:0] T_M = 3'd1;
   localparam logic [2:0] T_S = 3'd2;
   localparam logic [2:0] T_L = 3'd3;

   logic        clk, rst, rdy;
   logic        disp_valid;
   logic [5:0]  disp_op;
   logic [31:0] disp_imm, disp_datax, disp_datay;
   logic [2:0]  disp_tagx, disp_tagy;
   logic        full;
   logic        en_w0, en_w1, en_w2;
   logic [31:0] write_data0, write_data1, write_data2;
   logic        iss_valid, iss_ready;
   logic [5:0]  iss_op;
   logic [31:0] iss_x, iss_y, iss_imm;
`ifdef ALU_STATION_FLUSH_EN
   logic        flush;
`endif

   int total = 0;
   int bad   = 0;

   alu_station #(.DEPTH(4), .OP_W(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .rdy         (rdy),
`ifdef ALU_STATION_FLUSH_EN
      .flush       (flush),
`endif
      .disp_valid  (disp_valid),
      .disp_op     (disp_op),
      .disp_imm    (disp_imm),
      .disp_datax  (disp_datax),
      .disp_tagx   (disp_tagx),
      .disp_datay  (disp_datay),
      .disp_tagy   (disp_tagy),
      .full        (full),
      .en_w0       (en_w0),
      .write_data0 (write_data0),
      .en_w1       (en_w1),
      .write_data1 (write_data1),
      .en_w2       (en_w2),
      .write_data2 (write_data2),
      .iss_valid   (iss_valid),
      .iss_ready   (iss_ready),
      .iss_op      (iss_op),
      .iss_x       (iss_x),
      .iss_y       (iss_y),
      .iss_imm     (iss_imm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, act, exp);
      end
   endtask

   task automatic clear_inputs();
      disp_valid  = 1'b0;
      en_w0       = 1'b0;
      en_w1       = 1'b0;
      en_w2       = 1'b0;
      write_data0 = '0;
      write_data1 = '0;
      write_data2 = '0;
   endtask

   task automatic drive_disp(input logic [5:0] op, input logic [31:0] imm,
                             input logic [31:0] dx, input logic [2:0] tx,
                             input logic [31:0] dy, input logic [2:0] ty);
      disp_valid = 1'b1;
      disp_op    = op;
      disp_imm   = imm;
      disp_datax = dx;
      disp_tagx  = tx;
      disp_datay = dy;
      disp_tagy  = ty;
   endtask

   initial begin
`ifdef ALU_STATION_FLUSH_EN
      flush = 1'b0;
`endif
      rst = 1'b1; rdy = 1'b1; iss_ready = 1'b0;
      disp_op = '0; disp_imm = '0; disp_datax = '0; disp_datay = '0;
      disp_tagx = T_U; disp_tagy = T_U;
      clear_inputs();
      tick(); tick();
      rst = 1'b0;
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_valid", 32'(iss_valid), 32'd0);
      chk("rst_op", 32'(iss_op), 32'd0);
      chk("rst_x", iss_x, 32'd0);
      chk("rst_y", iss_y, 32'd0);
      chk("rst_imm", iss_imm, 32'd0);

      // Ready-at-dispatch: visible one cycle later, gone after the handshake.
      drive_disp(6'd5, 32'd9, 32'd7, T_U, 32'd3, T_U);
      iss_ready = 1'b1;
      tick(); clear_inputs();
      chk("t1_valid", 32'(iss_valid), 32'd1);
      chk("t1_op", 32'(iss_op), 32'd5);
      chk("t1_x", iss_x, 32'd7);
      chk("t1_y", iss_y, 32'd3);
      chk("t1_imm", iss_imm, 32'd9);
      tick();
      chk("t1_empty", 32'(iss_valid), 32'd0);
      chk("t1_full", 32'(full), 32'd0);

      // rdy low freezes: no dispatch taken, handshake ignored.
      iss_ready = 1'b0; rdy = 1'b0;
      drive_disp(6'd30, 32'd0, 32'h30, T_U, 32'h31, T_U);
      tick(); clear_inputs();
      chk("rdy_nodisp", 32'(iss_valid), 32'd0);
      rdy = 1'b1;
      drive_disp(6'd30, 32'd0, 32'h30, T_U, 32'h31, T_U);
      tick(); clear_inputs();
      chk("rdy_disp_op", 32'(iss_op), 32'd30);
      rdy = 1'b0; iss_ready = 1'b1;
      tick();
      chk("rdy_hold_valid", 32'(iss_valid), 32'd1);
      chk("rdy_hold_op", 32'(iss_op), 32'd30);
      rdy = 1'b1;
      tick();
      chk("rdy_issued", 32'(iss_valid), 32'd0);

      // Late wakeup on LOAD_STORE two cycles after dispatch.
      drive_disp(6'd2, 32'd0, 32'hdead, T_L, 32'd4, T_U);
      tick(); clear_inputs();
      chk("t2_wait0", 32'(iss_valid), 32'd0);
      tick();
      chk("t2_wait1", 32'(iss_valid), 32'd0);
      en_w2 = 1'b1; write_data2 = 32'h100;
      en_w0 = 1'b1; write_data0 = 32'hbad;
      tick(); clear_inputs();
      chk("t2_valid", 32'(iss_valid), 32'd1);
      chk("t2_op", 32'(iss_op), 32'd2);
      chk("t2_x", iss_x, 32'h100);
      chk("t2_y", iss_y, 32'd4);
      tick();
      chk("t2_empty", 32'(iss_valid), 32'd0);

      // Same-cycle broadcast forwarded into the dispatched operand.
      drive_disp(6'd7, 32'd0, 32'd1, T_U, 32'hdead, T_M);
      en_w0 = 1'b1; write_data0 = 32'hAB;
      tick(); clear_inputs();
      chk("t3_valid", 32'(iss_valid), 32'd1);
      chk("t3_x", iss_x, 32'd1);
      chk("t3_y", iss_y, 32'hAB);
      tick();
      chk("t3_empty", 32'(iss_valid), 32'd0);

      // Dispatch, issue and forwarding in one cycle.
      iss_ready = 1'b0;
      drive_disp(6'd40, 32'h40, 32'd1, T_U, 32'd2, T_U);
      tick(); clear_inputs();
      chk("t3b_first", 32'(iss_op), 32'd40);
      iss_ready = 1'b1;
      drive_disp(6'd41, 32'd0, 32'd0, T_M, 32'd5, T_U);
      en_w0 = 1'b1; write_data0 = 32'h41;
      tick(); clear_inputs();
      chk("t3b_op", 32'(iss_op), 32'd41);
      chk("t3b_x", iss_x, 32'h41);
      chk("t3b_y", iss_y, 32'd5);
      tick();
      chk("t3b_empty", 32'(iss_valid), 32'd0);

      // Fill, drop extra, out-of-order issue with compaction and shifted-copy wakeup.
      iss_ready = 1'b0;
      drive_disp(6'd10, 32'd0, 32'd0, T_M, 32'h10, T_U); tick();
      drive_disp(6'd11, 32'd0, 32'd0, T_S, 32'h21, T_U); tick();
      drive_disp(6'd12, 32'd0, 32'd0, T_L, 32'h12, T_U); tick();
      drive_disp(6'd13, 32'd0, 32'h33, T_U, 32'd0, T_S); tick();
      clear_inputs();
      chk("t4_full", 32'(full), 32'd1);
      chk("t4_none", 32'(iss_valid), 32'd0);
      drive_disp(6'd14, 32'd0, 32'hEE, T_U, 32'hEF, T_U);
      tick(); clear_inputs();
      chk("t4_drop_full", 32'(full), 32'd1);
      chk("t4_drop_none", 32'(iss_valid), 32'd0);
      en_w2 = 1'b1; write_data2 = 32'h222;
      tick(); clear_inputs();
      chk("t4_e2_op", 32'(iss_op), 32'd12);
      chk("t4_e2_x", iss_x, 32'h222);
      chk("t4_e2_y", iss_y, 32'h12);
      iss_ready = 1'b1;
      en_w0 = 1'b1; write_data0 = 32'h111;
      tick(); clear_inputs();
      iss_ready = 1'b0;
      chk("t4_after_full", 32'(full), 32'd0);
      chk("t4_e0_op", 32'(iss_op), 32'd10);
      chk("t4_e0_x", iss_x, 32'h111);
      chk("t4_e0_y", iss_y, 32'h10);
      iss_ready = 1'b1;
      en_w1 = 1'b1; write_data1 = 32'h555;
      tick(); clear_inputs();
      chk("t4_e1_op", 32'(iss_op), 32'd11);
      chk("t4_e1_x", iss_x, 32'h555);
      chk("t4_e1_y", iss_y, 32'h21);
      tick();
      chk("t4_e3_op", 32'(iss_op), 32'd13);
      chk("t4_e3_x", iss_x, 32'h33);
      chk("t4_e3_y", iss_y, 32'h555);
      tick();
      chk("t4_empty", 32'(iss_valid), 32'd0);
      chk("t4_empty_full", 32'(full), 32'd0);
      iss_ready = 1'b0;

      // Full with one ready entry: issue happens, dispatch dropped, three remain.
      drive_disp(6'd20, 32'd0, 32'd0, T_M, 32'd0, T_U); tick();
      drive_disp(6'd21, 32'd0, 32'h21, T_U, 32'h22, T_U); tick();
      drive_disp(6'd22, 32'd0, 32'd0, T_M, 32'd0, T_U); tick();
      drive_disp(6'd23, 32'd0, 32'd0, T_M, 32'd0, T_U); tick();
      clear_inputs();
      chk("t5_full", 32'(full), 32'd1);
      chk("t5_ready_op", 32'(iss_op), 32'd21);
      iss_ready = 1'b1;
      drive_disp(6'd24, 32'd0, 32'h24, T_U, 32'd0, T_U);
      tick(); clear_inputs();
      iss_ready = 1'b0;
      chk("t5_cnt3_full", 32'(full), 32'd0);
      chk("t5_dropped", 32'(iss_valid), 32'd0);
      drive_disp(6'd25, 32'd0, 32'h25, T_U, 32'd0, T_U);
      tick(); clear_inputs();
      chk("t5_cnt4_full", 32'(full), 32'd1);
      chk("t5_new_op", 32'(iss_op), 32'd25);
      chk("t5_new_x", iss_x, 32'h25);
      iss_ready = 1'b1;
      tick();
      iss_ready = 1'b0;
      chk("t5_left_full", 32'(full), 32'd0);
      chk("t5_left_none", 32'(iss_valid), 32'd0);

      // Reset with three locked entries and a concurrent matching broadcast.
      rst = 1'b1;
      en_w0 = 1'b1; write_data0 = 32'h77;
      tick(); clear_inputs();
      rst = 1'b0;
      chk("t6_full", 32'(full), 32'd0);
      chk("t6_valid", 32'(iss_valid), 32'd0);
      chk("t6_x", iss_x, 32'd0);
      iss_ready = 1'b1;
      en_w0 = 1'b1; write_data0 = 32'h99;
      tick(); clear_inputs();
      tick();
      chk("t6_stale", 32'(iss_valid), 32'd0);
      chk("t6_stale_full", 32'(full), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_station.md
Name: alu_station

Overview:
- Reservation station between the register status file and the ALU.
- Accepts one dispatched instruction per cycle. Operands arrive as {data, tag} pairs from the register status read ports.
- Captures missing operands by snooping the three result write-back buses, which are the same buses that write the register status file.
- Issues the oldest fully-ready entry to the ALU through a valid/ready handshake.

Parameters:
- DEPTH, 4, number of entries (2..8).
- OP_W, 6, width of the internal ALU opcode field.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- rdy  in  1  global enable; low freezes all state.
- disp_valid  in  1  dispatch request.
- disp_op  in  OP_W  ALU opcode.
- disp_imm  in  `word_t  immediate, carried through to issue.
- disp_datax  in  `word_t  operand x value.
- disp_tagx  in  `regtag_t  operand x tag; `UNLOCKED means the value is valid.
- disp_datay  in  `word_t  operand y value.
- disp_tagy  in  `regtag_t  operand y tag.
- full  out  1  station cannot accept a dispatch this cycle.
- en_w0 / write_data0  in  1 / `word_t  result broadcast from the unit tagged `ALU_MASTER.
- en_w1 / write_data1  in  1 / `word_t  result broadcast from the unit tagged `ALU_SALVER.
- en_w2 / write_data2  in  1 / `word_t  result broadcast from the unit tagged `LOAD_STORE.
- iss_valid  out  1  an entry is presented to the ALU.
- iss_ready  in  1  ALU accepts the presented entry.
- iss_op  out  OP_W  opcode of the issued entry.
- iss_x  out  `word_t  operand x of the issued entry.
- iss_y  out  `word_t  operand y of the issued entry.
- iss_imm  out  `word_t  immediate of the issued entry.

Behaviour:
- Entry storage: valid, op, imm, {datax, tagx}, {datay, tagy}. The array is compacting; index 0 is the oldest entry.
- Reset (rst high at posedge): all valid cleared, all tags `UNLOCKED, all data `ZERO. Outputs after reset: full=0, iss_valid=0, iss_op/iss_x/iss_y/iss_imm=0.
- rdy low: no state changes. Outputs hold their combinational values. A handshake completing while rdy is low is ignored.
- full is combinational from the registered valid count: full = (count == DEPTH). There is no bypass: when full, a dispatch is rejected even if an issue happens in the same cycle. A disp_valid asserted while full is dropped; upstream must not assert it.
- Wakeup, every cycle, for each stored operand with tag T != `UNLOCKED:
  - Capture write_dataN and set the tag to `UNLOCKED when en_wN is asserted and T matches port N's tag.
  - At most one port matches a given tag. If several match, port index 0 has the highest priority.
- Dispatch-cycle forwarding: a dispatched operand whose tag is matched by a same-cycle broadcast is written directly as {write_dataN, `UNLOCKED}. Without this the operand would be lost, because register status reads precede its write.
- Ready = valid and tagx == `UNLOCKED and tagy == `UNLOCKED, evaluated on registered state only. An entry woken this cycle issues at the earliest on the next cycle (one-cycle wakeup latency).
- Select: the lowest-index ready entry. iss_valid and iss_* are combinational from that entry. Outputs are zero when no entry is ready.
- On iss_valid & iss_ready:
  - The selected entry is removed.
  - Entries above it shift down by one. Wakeup captures apply to the shifted copies in the same cycle.
- New dispatch is written at index count, or count-1 if an issue removes an entry in the same cycle.
- Dispatch, wakeup and issue can all occur in one cycle; every combination must be supported.
- Minimum latency, dispatch to issue: 1 cycle. A dispatch with both operands unlocked is visible on iss_valid the cycle after disp_valid.

Optional Feature:
- Macro: ALU_STATION_FLUSH_EN.
- With the macro: an extra input port, flush (1 bit). When flush is high at posedge (and rdy=1), all entries are invalidated. flush has priority over a same-cycle dispatch, which is dropped. A same-cycle issue handshake still hands over the presented entry.
- Without the macro: no flush port. Entries leave only by issue or rst.

Decomposition:
- Shared definitions header: `word_t, `regtag_t, `UNLOCKED, `ALU_MASTER, `ALU_SALVER, `LOAD_STORE, `ZERO. The mapping of write-back port index to tag also lives there so it matches the register status file.
- Sub-module rs_pick: a DEPTH-wide lowest-index priority encoder producing a one-hot grant and the selected index.

Test Plan:
- Reset, then dispatch op=5, x={7,UNLOCKED}, y={3,UNLOCKED}, iss_ready=1 -> iss_valid=1 the next cycle with iss_x=7, iss_y=3, iss_op=5; station empty the cycle after.
- Dispatch with tagx=`LOAD_STORE, then en_w2=1, write_data2=0x100 two cycles later -> entry captures 0x100 and issues one cycle after the broadcast with iss_x=0x100.
- Dispatch tagy=`ALU_MASTER with en_w0=1, write_data0=0xAB in the same cycle -> forwarded; issues the next cycle with iss_y=0xAB.
- Fill to DEPTH=4 with locked operands and hold iss_ready=0 -> full=1 and an extra dispatch is dropped. Unlock entry 2, then entry 0 -> entry 2 issues first, and entries 3 then 0 compact correctly.
- Full station, iss_ready=1 with one ready entry, disp_valid=1 -> issue occurs, dispatch is dropped, count=3.
- Assert rst while 3 entries are pending and a broadcast arrives -> the next cycle full=0, iss_valid=0, and no later issue of stale entries.
